// File: rtl/axi4l_reg_slice.sv
// AXI4-Lite register slice: one 2-entry skid buffer per channel.
// Every output is a flop, so no combinational path crosses the slice.

module axi4l_reg_slice_buf #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         push, pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end else if (push) begin
          skid_d  = in_data;
          state_d = TWO;
        end
      end
      TWO: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  // ready stays low through reset and rises on the first clean edge
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

module axi4l_reg_slice #(
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                s_axi_awprot,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                s_axi_arprot,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int AW_W = C_ADDR_WIDTH + 3;
  localparam int W_W  = C_DATA_WIDTH + C_DATA_WIDTH / 8;
  localparam int R_W  = C_DATA_WIDTH + 2;

  if (C_DATA_WIDTH != 32 && C_DATA_WIDTH != 64) begin : g_bad_width
    $error("axi4l_reg_slice: C_DATA_WIDTH must be 32 or 64");
  end

  logic [AW_W-1:0] aw_out, ar_out;
  logic [W_W-1:0]  w_out;
  logic [R_W-1:0]  r_out;
  logic [1:0]      b_out;

  axi4l_reg_slice_buf #(.W(AW_W)) u_aw (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (s_axi_awvalid),
    .in_ready  (s_axi_awready),
    .in_data   ({s_axi_awaddr, s_axi_awprot}),
    .out_valid (m_axi_awvalid),
    .out_ready (m_axi_awready),
    .out_data  (aw_out)
  );

  axi4l_reg_slice_buf #(.W(W_W)) u_w (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (s_axi_wvalid),
    .in_ready  (s_axi_wready),
    .in_data   ({s_axi_wdata, s_axi_wstrb}),
    .out_valid (m_axi_wvalid),
    .out_ready (m_axi_wready),
    .out_data  (w_out)
  );

  axi4l_reg_slice_buf #(.W(2)) u_b (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (m_axi_bvalid),
    .in_ready  (m_axi_bready),
    .in_data   (m_axi_bresp),
    .out_valid (s_axi_bvalid),
    .out_ready (s_axi_bready),
    .out_data  (b_out)
  );

  axi4l_reg_slice_buf #(.W(AW_W)) u_ar (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (s_axi_arvalid),
    .in_ready  (s_axi_arready),
    .in_data   ({s_axi_araddr, s_axi_arprot}),
    .out_valid (m_axi_arvalid),
    .out_ready (m_axi_arready),
    .out_data  (ar_out)
  );

  axi4l_reg_slice_buf #(.W(R_W)) u_r (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (m_axi_rvalid),
    .in_ready  (m_axi_rready),
    .in_data   ({m_axi_rdata, m_axi_rresp}),
    .out_valid (s_axi_rvalid),
    .out_ready (s_axi_rready),
    .out_data  (r_out)
  );

  assign {m_axi_awaddr, m_axi_awprot} = aw_out;
  assign {m_axi_wdata, m_axi_wstrb}   = w_out;
  assign s_axi_bresp                  = b_out;
  assign {m_axi_araddr, m_axi_arprot} = ar_out;
  assign {s_axi_rdata, s_axi_rresp}   = r_out;

endmodule

// File: tb/tb_axi4l_reg_slice.sv
// Bench for axi4l_reg_slice: per-channel FIFO scoreboard with
// occupancy-based ready/valid model, directed and random traffic.

module tb_axi4l_reg_slice;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [AW-1:0] s_axi_awaddr = '0;
  logic [2:0]    s_axi_awprot = '0;
  logic          s_axi_awvalid = 1'b0;
  logic          s_axi_awready;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [3:0]    s_axi_wstrb = '0;
  logic          s_axi_wvalid = 1'b0;
  logic          s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready = 1'b1;
  logic [AW-1:0] s_axi_araddr = '0;
  logic [2:0]    s_axi_arprot = '0;
  logic          s_axi_arvalid = 1'b0;
  logic          s_axi_arready;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rvalid;
  logic          s_axi_rready = 1'b1;
  logic [AW-1:0] m_axi_awaddr;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_awvalid;
  logic          m_axi_awready = 1'b1;
  logic [DW-1:0] m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wvalid;
  logic          m_axi_wready = 1'b1;
  logic [1:0]    m_axi_bresp = '0;
  logic          m_axi_bvalid = 1'b0;
  logic          m_axi_bready;
  logic [AW-1:0] m_axi_araddr;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b1;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = '0;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;

  always #5 aclk = ~aclk;

  axi4l_reg_slice #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  logic [71:0] sbq [5][$];
  bit          hold [5];
  logic [71:0] hold_pl [5];
  int          npop [5];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        rst_edge = 1'b0;

  // reset level seen by the DUT at its most recent edge
  always @(posedge aclk) rst_edge = aresetn;

  function automatic string cname(input int ch);
    case (ch)
      0: return "AW";
      1: return "W";
      2: return "B";
      3: return "AR";
      default: return "R";
    endcase
  endfunction

  task automatic expect_eq(input string nm, input logic [71:0] act,
                           input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk(input int ch,
                     input logic iv, input logic ir, input logic [71:0] ip,
                     input logic ov, input logic orr, input logic [71:0] op);
    string nm;
    nm = cname(ch);
    if (!rst_edge) begin
      expect_eq({nm, " reset ready"}, 72'(ir), 72'd0);
      expect_eq({nm, " reset valid"}, 72'(ov), 72'd0);
      expect_eq({nm, " reset payload"}, op, 72'd0);
      sbq[ch].delete();
      hold[ch] = 1'b0;
      return;
    end
    if (hold[ch]) begin
      expect_eq({nm, " stall valid held"}, 72'(ov), 72'd1);
      expect_eq({nm, " stall payload held"}, op, hold_pl[ch]);
    end
    expect_eq({nm, " in_ready"}, 72'(ir), 72'(sbq[ch].size() < 2));
    expect_eq({nm, " out_valid"}, 72'(ov), 72'(sbq[ch].size() > 0));
    if (sbq[ch].size() > 0)
      expect_eq({nm, " payload order"}, op, sbq[ch][0]);
    hold[ch] = 1'b0;
    if (aresetn) begin
      if (ov && orr && sbq[ch].size() > 0) begin
        void'(sbq[ch].pop_front());
        npop[ch]++;
      end
      if (iv && ir) sbq[ch].push_back(ip);
      hold[ch]    = ov && !orr;
      hold_pl[ch] = op;
    end
  endtask

  always @(negedge aclk) begin
    chk(0, s_axi_awvalid, s_axi_awready, 72'({s_axi_awaddr, s_axi_awprot}),
        m_axi_awvalid, m_axi_awready, 72'({m_axi_awaddr, m_axi_awprot}));
    chk(1, s_axi_wvalid, s_axi_wready, 72'({s_axi_wdata, s_axi_wstrb}),
        m_axi_wvalid, m_axi_wready, 72'({m_axi_wdata, m_axi_wstrb}));
    chk(2, m_axi_bvalid, m_axi_bready, 72'(m_axi_bresp),
        s_axi_bvalid, s_axi_bready, 72'(s_axi_bresp));
    chk(3, s_axi_arvalid, s_axi_arready, 72'({s_axi_araddr, s_axi_arprot}),
        m_axi_arvalid, m_axi_arready, 72'({m_axi_araddr, m_axi_arprot}));
    chk(4, m_axi_rvalid, m_axi_rready, 72'({m_axi_rdata, m_axi_rresp}),
        s_axi_rvalid, s_axi_rready, 72'({s_axi_rdata, s_axi_rresp}));
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic pct(input int p);
    return ($urandom_range(0, 99) < p);
  endfunction

  initial begin
    int p0;
    bit acc;
    repeat (4) step();
    aresetn = 1'b1;
    step();
    expect_eq("ready after reset",
              72'({s_axi_awready, s_axi_wready, s_axi_arready,
                   m_axi_bready, m_axi_rready}), 72'h1f);

    // streaming AR at full rate
    p0 = npop[3];
    for (int i = 0; i < 16; i++) begin
      s_axi_arvalid = 1'b1;
      s_axi_araddr  = AW'(i * 4);
      s_axi_arprot  = 3'd0;
      step();
    end
    s_axi_arvalid = 1'b0;
    step();
    expect_eq("AR stream beats", 72'(npop[3] - p0), 72'd16);

    // W backpressure: two absorbed, third held upstream
    p0 = npop[1];
    m_axi_wready = 1'b0;
    s_axi_wvalid = 1'b1;
    s_axi_wstrb  = 4'hf;
    s_axi_wdata  = 32'hA5A5A5A5;
    step();
    s_axi_wdata  = 32'h5A5A5A5A;
    step();
    expect_eq("W ready low when full", 72'(s_axi_wready), 72'd0);
    s_axi_wdata  = 32'h12345678;
    repeat (3) step();
    expect_eq("W ready stays low", 72'(s_axi_wready), 72'd0);
    m_axi_wready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      @(negedge aclk);
      if (s_axi_wready) acc = 1'b1;
    end
    expect_eq("W third beat accepted", 72'(acc), 72'd1);
    step();
    s_axi_wvalid = 1'b0;
    repeat (3) step();
    expect_eq("W drained beats", 72'(npop[1] - p0), 72'd3);

    // B reverse channel held under s_bready=0
    s_axi_bready = 1'b0;
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = 2'b10;
    step();
    m_axi_bvalid = 1'b0;
    p0 = npop[2];
    for (int k = 0; k < 5; k++) begin
      expect_eq("B valid held", 72'(s_axi_bvalid), 72'd1);
      expect_eq("B resp held", 72'(s_axi_bresp), 72'd2);
      step();
    end
    s_axi_bready = 1'b1;
    step();
    expect_eq("B popped once", 72'(npop[2] - p0), 72'd1);
    expect_eq("B valid cleared", 72'(s_axi_bvalid), 72'd0);

    // random traffic on all channels, with one mid-run reset
    for (int cyc = 0; cyc < 10000; cyc++) begin
      aresetn = !(cyc >= 5000 && cyc < 5003);
      s_axi_awvalid = pct(70);
      s_axi_awaddr  = AW'($urandom);
      s_axi_awprot  = 3'($urandom);
      s_axi_wvalid  = pct(70);
      s_axi_wdata   = $urandom;
      s_axi_wstrb   = 4'($urandom);
      m_axi_bvalid  = pct(60);
      m_axi_bresp   = 2'($urandom);
      s_axi_arvalid = pct(70);
      s_axi_araddr  = AW'($urandom);
      s_axi_arprot  = 3'($urandom);
      m_axi_rvalid  = pct(60);
      m_axi_rdata   = $urandom;
      m_axi_rresp   = 2'($urandom);
      m_axi_awready = pct(60);
      m_axi_wready  = pct(60);
      s_axi_bready  = pct(70);
      m_axi_arready = pct(60);
      s_axi_rready  = pct(70);
      step();
    end

    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    m_axi_bvalid  = 1'b0;
    s_axi_arvalid = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    s_axi_bready  = 1'b1;
    m_axi_arready = 1'b1;
    s_axi_rready  = 1'b1;
    repeat (5) step();
    for (int ch = 0; ch < 5; ch++)
      expect_eq({cname(ch), " drained"}, 72'(sbq[ch].size()), 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
